// File: rtl/fp16_rmul_arbiter_if.sv
// Requester-side handshake bundle for fp16_rmul_arbiter: two operand request
// channels and two result channels, each with a valid/ready handshake.
interface fp16_rmul_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req0_ready;
    logic        req1_ready;
    logic        resp0_valid;
    logic        resp1_valid;
    logic [15:0] resp0_data;
    logic [15:0] resp1_data;
    logic        resp0_ready;
    logic        resp1_ready;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp0_data, resp1_data,
        input  resp0_ready, resp1_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp0_data, resp1_data,
        output resp0_ready, resp1_ready
    );
endinterface

// File: rtl/fp16_rmul_arbiter.sv
// Two-requester round-robin front end for an external two-stage FP16 multiplier.
// Define FP16_RMUL_ARB_STATS_EN to add the 16-bit wrapping issue counter.
module fp16_rmul_arbiter (
    input  logic                      clk,
    input  logic                      rst,
    fp16_rmul_arbiter_if.slave        bus,
    output logic [15:0]               s0_arg_0,
    output logic [15:0]               s0_arg_1,
    input  logic                      s0_ret_0,
    input  logic [4:0]                s0_ret_1,
    input  logic [4:0]                s0_ret_2,
    input  logic [11:0]               s0_ret_3,
    output logic                      s1_arg_0,
    output logic [4:0]                s1_arg_1,
    output logic [4:0]                s1_arg_2,
    output logic [11:0]               s1_arg_3,
    input  logic [15:0]               s1_ret_0,
    output logic [15:0]               issue_count
);

    logic        r_busy0;
    logic        r_busy1;
    logic        r_last;
    logic        r_v1;
    logic        r_tag;
    logic        r_p1_sign;
    logic [4:0]  r_p1_ea;
    logic [4:0]  r_p1_eb;
    logic [11:0] r_p1_frac;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [15:0] r_resp0_data;
    logic [15:0] r_resp1_data;

    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_consume0;
    logic w_consume1;

    assign w_elig0 = bus.req0_valid && !r_busy0;
    assign w_elig1 = bus.req1_valid && !r_busy1;

    // Tie goes to whoever was not granted last; grants are forced off during reset.
    assign w_grant0 = !rst && w_elig0 && (!w_elig1 || r_last);
    assign w_grant1 = !rst && w_elig1 && (!w_elig0 || !r_last);
    assign w_accept = w_grant0 || w_grant1;

    assign w_consume0 = r_resp0_valid && bus.resp0_ready;
    assign w_consume1 = r_resp1_valid && bus.resp1_ready;

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    always_comb begin
        s0_arg_0 = 16'd0;
        s0_arg_1 = 16'd0;
        if (w_grant0) begin
            s0_arg_0 = bus.req0_a;
            s0_arg_1 = bus.req0_b;
        end else if (w_grant1) begin
            s0_arg_0 = bus.req1_a;
            s0_arg_1 = bus.req1_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy0 <= 1'b0;
            r_busy1 <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (w_grant0)
                r_busy0 <= 1'b1;
            else if (w_consume0)
                r_busy0 <= 1'b0;
            if (w_grant1)
                r_busy1 <= 1'b1;
            else if (w_consume1)
                r_busy1 <= 1'b0;
            if (w_grant0)
                r_last <= 1'b0;
            else if (w_grant1)
                r_last <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1      <= 1'b0;
            r_tag     <= 1'b0;
            r_p1_sign <= 1'b0;
            r_p1_ea   <= 5'd0;
            r_p1_eb   <= 5'd0;
            r_p1_frac <= 12'd0;
        end else if (w_accept) begin
            r_v1      <= 1'b1;
            r_tag     <= w_grant1;
            r_p1_sign <= s0_ret_0;
            r_p1_ea   <= s0_ret_1;
            r_p1_eb   <= s0_ret_2;
            r_p1_frac <= s0_ret_3;
        end else begin
            r_v1 <= 1'b0;
        end
    end

    assign s1_arg_0 = r_p1_sign;
    assign s1_arg_1 = r_p1_ea;
    assign s1_arg_2 = r_p1_eb;
    assign s1_arg_3 = r_p1_frac;

    // A new result for N implies N was idle, so set never collides with consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= 16'd0;
            r_resp1_data  <= 16'd0;
        end else begin
            if (r_v1 && !r_tag) begin
                r_resp0_valid <= 1'b1;
                r_resp0_data  <= s1_ret_0;
            end else if (w_consume0) begin
                r_resp0_valid <= 1'b0;
            end
            if (r_v1 && r_tag) begin
                r_resp1_valid <= 1'b1;
                r_resp1_data  <= s1_ret_0;
            end else if (w_consume1) begin
                r_resp1_valid <= 1'b0;
            end
        end
    end

    assign bus.resp0_valid = r_resp0_valid;
    assign bus.resp1_valid = r_resp1_valid;
    assign bus.resp0_data  = r_resp0_data;
    assign bus.resp1_data  = r_resp1_data;

`ifdef FP16_RMUL_ARB_STATS_EN
    logic [15:0] r_issue_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_issue_count <= 16'd0;
        else if (w_accept)
            r_issue_count <= r_issue_count + 16'd1;
    end

    assign issue_count = r_issue_count;
`else
    assign issue_count = 16'd0;
`endif

endmodule

// File: tb/tb_fp16_rmul_arbiter.sv
// Directed bench for fp16_rmul_arbiter; supplies a behavioural two-stage FP16
// multiplier (flush-to-zero) on the s0/s1 ports and checks hand-computed results.
module tb_fp16_rmul_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_rmul_arbiter_if bus();

    logic [15:0] s0_arg_0, s0_arg_1;
    logic        s0_ret_0;
    logic [4:0]  s0_ret_1, s0_ret_2;
    logic [11:0] s0_ret_3;
    logic        s1_arg_0;
    logic [4:0]  s1_arg_1, s1_arg_2;
    logic [11:0] s1_arg_3;
    logic [15:0] s1_ret_0;
    logic [15:0] issue_count;

    fp16_rmul_arbiter dut (
        .clk(clk), .rst(rst), .bus(bus),
        .s0_arg_0(s0_arg_0), .s0_arg_1(s0_arg_1),
        .s0_ret_0(s0_ret_0), .s0_ret_1(s0_ret_1), .s0_ret_2(s0_ret_2), .s0_ret_3(s0_ret_3),
        .s1_arg_0(s1_arg_0), .s1_arg_1(s1_arg_1), .s1_arg_2(s1_arg_2), .s1_arg_3(s1_arg_3),
        .s1_ret_0(s1_ret_0), .issue_count(issue_count)
    );

    // Stage 0: sign, both exponents, top 12 bits of the 22-bit significand product.
    logic [10:0] m_a, m_b;
    logic [21:0] m_prod;
    always_comb begin
        m_a      = {1'b1, s0_arg_0[9:0]};
        m_b      = {1'b1, s0_arg_1[9:0]};
        m_prod   = 22'(m_a) * 22'(m_b);
        s0_ret_0 = s0_arg_0[15] ^ s0_arg_1[15];
        s0_ret_1 = s0_arg_0[14:10];
        s0_ret_2 = s0_arg_1[14:10];
        s0_ret_3 = m_prod[21:10];
    end

    // Stage 1: normalise, flush subnormal inputs/results to zero, saturate to inf.
    int e_sum;
    always_comb begin
        e_sum = int'(s1_arg_1) + int'(s1_arg_2) - 15 + (s1_arg_3[11] ? 1 : 0);
        if (s1_arg_1 == 5'd0 || s1_arg_2 == 5'd0 || e_sum <= 0)
            s1_ret_0 = {s1_arg_0, 15'd0};
        else if (e_sum >= 31)
            s1_ret_0 = {s1_arg_0, 5'h1F, 10'd0};
        else if (s1_arg_3[11])
            s1_ret_0 = {s1_arg_0, e_sum[4:0], s1_arg_3[10:1]};
        else
            s1_ret_0 = {s1_arg_0, e_sum[4:0], s1_arg_3[9:0]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input logic [15:0] act, input logic [15:0] exp, input string nm);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic rvalid(input int n);
        return (n == 0) ? bus.resp0_valid : bus.resp1_valid;
    endfunction

    function automatic logic [15:0] rdata(input int n);
        return (n == 0) ? bus.resp0_data : bus.resp1_data;
    endfunction

    task automatic drive_req(input int n, input logic v, input logic [15:0] a, input logic [15:0] b);
        if (n == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Single operation with resp_ready high: 2-clock latency, consumed one clock later.
    task automatic do_op(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p, input string nm);
        int k;
        @(negedge clk);
        drive_req(n, 1'b1, a, b);
        #1;
        k = 0;
        while (!rdy(n) && k < 10) begin
            @(negedge clk); #1; k++;
        end
        chk(16'(rdy(n)), 16'd1, {nm, " ready"});
        chk(s0_arg_0, a, {nm, " s0_arg_0"});
        @(posedge clk);
        @(negedge clk);
        drive_req(n, 1'b0, 16'd0, 16'd0);
        #1;
        chk(16'(rvalid(n)), 16'd0, {nm, " resp early"});
        @(negedge clk); #1;
        chk(16'(rvalid(n)), 16'd1, {nm, " resp valid"});
        chk(rdata(n), p, {nm, " resp data"});
        chk(16'(rvalid(1 - n)), 16'd0, {nm, " other resp idle"});
        @(negedge clk); #1;
        chk(16'(rvalid(n)), 16'd0, {nm, " resp consumed"});
    endtask

    typedef struct {
        int          n;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[8];
    int   grants[8];
    int   ng;

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h3C00, 16'h3C00, 16'h3C00};  // 1*1
        vecs[1] = '{1, 16'h3C00, 16'h3C00, 16'h3C00};
        vecs[2] = '{0, 16'h4000, 16'h4200, 16'h4600};  // 2*3 = 6
        vecs[3] = '{1, 16'h0400, 16'h3800, 16'h0000};  // 2^-14 * 0.5 underflows
        vecs[4] = '{0, 16'hC000, 16'h3C00, 16'hC000};  // -2*1
        vecs[5] = '{1, 16'h3A00, 16'h3A00, 16'h3880};  // 0.75^2
        vecs[6] = '{0, 16'h3E00, 16'h3E00, 16'h4080};  // 1.5^2
        vecs[7] = '{1, 16'h0000, 16'h3C00, 16'h0000};  // zero operand

        rst = 1'b1;
        drive_req(0, 1'b1, 16'h3C00, 16'h3C00);
        drive_req(1, 1'b1, 16'h3C00, 16'h3C00);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        #1;
        chk(16'(bus.req0_ready), 16'd0, "rst req0_ready");
        chk(16'(bus.req1_ready), 16'd0, "rst req1_ready");
        chk(s0_arg_0, 16'd0, "rst s0_arg_0");
        chk(16'(bus.resp0_valid), 16'd0, "rst resp0_valid");
        chk(issue_count, 16'd0, "rst issue_count");
        drive_req(0, 1'b0, 16'd0, 16'd0);
        drive_req(1, 1'b0, 16'd0, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First tie after reset goes to requester 0.
        @(negedge clk);
        drive_req(0, 1'b1, 16'h3E00, 16'h3E00);
        drive_req(1, 1'b1, 16'h3A00, 16'h3A00);
        #1;
        chk(16'(bus.req0_ready), 16'd1, "tie req0_ready");
        chk(16'(bus.req1_ready), 16'd0, "tie req1_ready");
        chk(s0_arg_0, 16'h3E00, "tie s0_arg_0");
        @(negedge clk);
        drive_req(0, 1'b0, 16'd0, 16'd0);
        #1;
        chk(16'(bus.req1_ready), 16'd1, "tie2 req1_ready");
        chk(s0_arg_0, 16'h3A00, "tie2 s0_arg_0");
        @(negedge clk);
        drive_req(1, 1'b0, 16'd0, 16'd0);
        #1;
        chk(16'(bus.resp0_valid), 16'd1, "tie resp0_valid");
        chk(bus.resp0_data, 16'h4080, "tie resp0_data");
        chk(16'(bus.resp1_valid), 16'd0, "tie resp1 not yet");
        @(negedge clk); #1;
        chk(16'(bus.resp1_valid), 16'd1, "tie resp1_valid");
        chk(bus.resp1_data, 16'h3880, "tie resp1_data");
        chk(16'(bus.resp0_valid), 16'd0, "tie resp0 consumed");
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            do_op(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // Back-pressure: held result blocks re-grant until consumed, then grant next cycle.
        bus.resp0_ready = 1'b0;
        @(negedge clk);
        drive_req(0, 1'b1, 16'h3C00, 16'h4000);
        #1;
        chk(16'(bus.req0_ready), 16'd1, "bp first grant");
        @(negedge clk); #1;
        chk(16'(bus.req0_ready), 16'd0, "bp busy");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk(16'(bus.resp0_valid), 16'd1, "bp resp held");
            chk(bus.resp0_data, 16'h4000, "bp data stable");
            chk(16'(bus.req0_ready), 16'd0, "bp no regrant");
        end
        bus.resp0_ready = 1'b1;
        drive_req(0, 1'b1, 16'h4000, 16'h4000);
        #1;
        chk(16'(bus.req0_ready), 16'd0, "bp no grant in consume cycle");
        @(negedge clk);
        bus.resp0_ready = 1'b0;
        #1;
        chk(16'(bus.resp0_valid), 16'd0, "bp consumed");
        chk(16'(bus.req0_ready), 16'd1, "bp regrant");
        @(negedge clk);
        drive_req(0, 1'b0, 16'd0, 16'd0);
        bus.resp0_ready = 1'b1;
        @(negedge clk); #1;
        chk(bus.resp0_data, 16'h4400, "bp second result");
        repeat (2) @(negedge clk);

        // Streaming: both requesters always valid, grants must alternate 0,1,0,1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_req(0, 1'b1, 16'h3C00, 16'h3C00);
        drive_req(1, 1'b1, 16'h3C00, 16'h3C00);
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            #1;
            chk(16'(bus.req0_ready & bus.req1_ready), 16'd0, "stream single grant");
            if (bus.req0_ready) begin grants[ng] = 0; ng++; end
            else if (bus.req1_ready) begin grants[ng] = 1; ng++; end
            @(negedge clk);
        end
        drive_req(0, 1'b0, 16'd0, 16'd0);
        drive_req(1, 1'b0, 16'd0, 16'd0);
        chk(16'(ng), 16'd8, "stream grant count");
        for (int i = 0; i < ng; i++)
            chk(16'(grants[i]), 16'(i % 2), $sformatf("stream grant%0d", i));
        #1;
`ifdef FP16_RMUL_ARB_STATS_EN
        chk(issue_count, 16'd8, "stream issue_count");
`else
        chk(issue_count, 16'd0, "stream issue_count");
`endif
        repeat (4) @(negedge clk);

        // Reset one cycle after acceptance discards the in-flight operation.
        drive_req(1, 1'b1, 16'h3C00, 16'h3C00);
        #1;
        chk(16'(bus.req1_ready), 16'd1, "abort grant");
        @(negedge clk);
        drive_req(1, 1'b0, 16'd0, 16'd0);
        #1;
        chk(16'(s1_arg_1), 16'd15, "abort p1 loaded");
        drive_req(0, 1'b1, 16'h3C00, 16'h3C00);
        #1;
        rst = 1'b1;
        #1;
        chk(16'(s1_arg_1), 16'd0, "abort s1_arg_1");
        chk(16'(s1_arg_3), 16'd0, "abort s1_arg_3");
        chk(16'(bus.req0_ready), 16'd0, "abort req0_ready");
        chk(s0_arg_0, 16'd0, "abort s0_arg_0");
        chk(issue_count, 16'd0, "abort issue_count");
        chk(16'(bus.resp1_valid), 16'd0, "abort resp1_valid");
        @(negedge clk);
        drive_req(0, 1'b0, 16'd0, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk(16'(bus.resp1_valid), 16'd0, "abort never reported");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
